// File: rtl/in_polygon_stream.sv
// in_polygon_stream: multi-cycle point-in-polygon engine, LANES edges per cycle, even-odd parity and optional winding number
//   Optional feature macro: IN_POLYGON_WINDING_EN (winding accumulator, mode_in selects nonzero rule)
//   Ports: clk_in/rst_in (async active-high), valid_in/ready_out query handshake, x_in/y_in query point,
//   poly_xs_in/poly_ys_in vertex lists, num_points_in vertex count, mode_in rule select, busy_out query in flight,
//   valid_out/ready_in result handshake, inside_out result, winding_out signed winding number.
module in_polygon_stream #(
    parameter int WORLD_BITS       = 32,
    parameter int MAX_NUM_VERTICES = 32,
    parameter int LANES            = 4
) (
    input  logic                                        clk_in,
    input  logic                                        rst_in,
    input  logic                                        valid_in,
    output logic                                        ready_out,
    input  logic signed [WORLD_BITS-1:0]                x_in,
    input  logic signed [WORLD_BITS-1:0]                y_in,
    input  logic signed [WORLD_BITS-1:0]                poly_xs_in [MAX_NUM_VERTICES],
    input  logic signed [WORLD_BITS-1:0]                poly_ys_in [MAX_NUM_VERTICES],
    input  logic        [$clog2(MAX_NUM_VERTICES+1)-1:0] num_points_in,
    input  logic                                        mode_in,
    output logic                                        busy_out,
    output logic                                        valid_out,
    input  logic                                        ready_in,
    output logic                                        inside_out,
    output logic signed [$clog2(MAX_NUM_VERTICES+1):0]   winding_out
);
    localparam int NW = $clog2(MAX_NUM_VERTICES + 1);
    localparam int WW = NW + 1;
    localparam int DW = WORLD_BITS + 1;
    localparam int PW = 2 * WORLD_BITS + 3;
    localparam int EW = $clog2(MAX_NUM_VERTICES + LANES + 1);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN1, DRAIN2, DONE} state_t;
    state_t state_q, state_d;
    logic signed [WORLD_BITS-1:0] x_q, x_d, y_q, y_d;
    logic [NW-1:0] n_q, n_d, nc;
    logic [EW-1:0] base_q, base_d;
    logic parity_q, parity_d, inside_q, inside_d, accept, fin_inside;
    logic [LANES-1:0] s1_ib_q, s1_ib_d, s1_dir_q, s1_dir_d, cross_q, cross_d, dir2_q, dir2_d;
    logic signed [DW-1:0] dxl_q [LANES], dxl_d [LANES], dyp_q [LANES], dyp_d [LANES];
    logic signed [DW-1:0] dyl_q [LANES], dyl_d [LANES], dxp_q [LANES], dxp_d [LANES];
    logic [EW-1:0] e, e1;
    logic act;
    int i0, i1;
    logic signed [DW-1:0] ax, ay, bx, by, hx, hy, lx, ly, px, py;
    logic signed [PW-1:0] pa, pb, pc, pd, prod;
    assign accept = state_q == IDLE && valid_in;
    assign nc = num_points_in > NW'(MAX_NUM_VERTICES) ? NW'(MAX_NUM_VERTICES) : num_points_in;
    assign ready_out = state_q == IDLE;
    assign busy_out = state_q != IDLE;
    assign valid_out = state_q == DONE;
    assign inside_out = inside_q;
    // Stage 1: fetch edge endpoints, order by y, test half-open y span, form differences.
    always_comb begin
        e = '0;
        e1 = '0;
        act = 1'b0;
        i0 = 0;
        i1 = 0;
        {ax, ay, bx, by, hx, hy, lx, ly} = '0;
        px = DW'(x_q);
        py = DW'(y_q);
        s1_ib_d = '0;
        s1_dir_d = '0;
        for (int l = 0; l < LANES; l++) begin
            e = base_q + EW'(l);
            act = state_q == RUN && e < EW'(n_q);
            e1 = e + EW'(1) == EW'(n_q) ? '0 : e + EW'(1);
            i0 = act ? int'(e) : 0;
            i1 = act ? int'(e1) : 0;
            ax = DW'(poly_xs_in[i0]);
            ay = DW'(poly_ys_in[i0]);
            bx = DW'(poly_xs_in[i1]);
            by = DW'(poly_ys_in[i1]);
            hx = by > ay ? bx : ax;
            hy = by > ay ? by : ay;
            lx = by > ay ? ax : bx;
            ly = by > ay ? ay : by;
            s1_ib_d[l] = act && hy > py && py >= ly;
            s1_dir_d[l] = by < ay;
            dxl_d[l] = lx - hx;
            dyp_d[l] = py - hy;
            dyl_d[l] = ly - hy;
            dxp_d[l] = px - hx;
        end
    end
    // Stage 2: full-width cross product sign decides the crossing.
    always_comb begin
        {pa, pb, pc, pd, prod} = '0;
        cross_d = '0;
        dir2_d = s1_dir_q;
        for (int l = 0; l < LANES; l++) begin
            pa = PW'(dxl_q[l]);
            pb = PW'(dyp_q[l]);
            pc = PW'(dyl_q[l]);
            pd = PW'(dxp_q[l]);
            prod = pa * pb - pc * pd;
            cross_d[l] = s1_ib_q[l] && !prod[PW-1];
        end
    end
    always_comb parity_d = accept ? 1'b0 : parity_q ^ (^cross_q);
`ifdef IN_POLYGON_WINDING_EN
    logic mode_q, mode_d;
    logic signed [WW-1:0] wind_q, wind_d, ws, wout_q, wout_d;
    always_comb begin
        ws = '0;
        for (int l = 0; l < LANES; l++)
            ws = ws + (cross_q[l] ? (dir2_q[l] ? WW'(1) : -WW'(1)) : WW'(0));
        mode_d = accept ? mode_in : mode_q;
        wind_d = accept ? '0 : wind_q + ws;
        wout_d = accept ? '0 : (state_q == DRAIN2 ? wind_d : wout_q);
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mode_q <= 1'b0;
            wind_q <= '0;
            wout_q <= '0;
        end else begin
            mode_q <= mode_d;
            wind_q <= wind_d;
            wout_q <= wout_d;
        end
    end
    assign winding_out = wout_q;
    assign fin_inside = mode_q ? wind_d != '0 : parity_d;
`else
    logic unused_ok;
    assign unused_ok = mode_in ^ (^dir2_q);
    assign winding_out = '0;
    assign fin_inside = parity_d;
`endif
    always_comb begin
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        n_d = n_q;
        base_d = base_q;
        inside_d = inside_q;
        case (state_q)
            IDLE: if (valid_in) begin
                x_d = x_in;
                y_d = y_in;
                n_d = nc;
                base_d = '0;
                inside_d = 1'b0;
                state_d = nc < NW'(3) ? DONE : RUN;
            end
            RUN: begin
                base_d = base_q + EW'(LANES);
                state_d = base_q + EW'(LANES) >= EW'(n_q) ? DRAIN1 : RUN;
            end
            DRAIN1: state_d = DRAIN2;
            DRAIN2: begin
                state_d = DONE;
                inside_d = fin_inside;
            end
            DONE: state_d = ready_in ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            x_q <= '0;
            y_q <= '0;
            n_q <= '0;
            base_q <= '0;
            parity_q <= 1'b0;
            inside_q <= 1'b0;
            s1_ib_q <= '0;
            s1_dir_q <= '0;
            cross_q <= '0;
            dir2_q <= '0;
            for (int l = 0; l < LANES; l++) begin
                dxl_q[l] <= '0;
                dyp_q[l] <= '0;
                dyl_q[l] <= '0;
                dxp_q[l] <= '0;
            end
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            n_q <= n_d;
            base_q <= base_d;
            parity_q <= parity_d;
            inside_q <= inside_d;
            s1_ib_q <= s1_ib_d;
            s1_dir_q <= s1_dir_d;
            cross_q <= cross_d;
            dir2_q <= dir2_d;
            for (int l = 0; l < LANES; l++) begin
                dxl_q[l] <= dxl_d[l];
                dyp_q[l] <= dyp_d[l];
                dyl_q[l] <= dyl_d[l];
                dxp_q[l] <= dxp_d[l];
            end
        end
    end
endmodule

// File: tb/tb_in_polygon_stream.sv
// tb_in_polygon_stream: directed checks of in_polygon_stream
module tb_in_polygon_stream;
    logic clk = 0, rst = 1, valid_in = 0, ready_in = 0, mode = 0;
    logic ready_out, busy_out, valid_out, inside_out;
    logic signed [31:0] x = 0, y = 0;
    logic signed [31:0] pxs [32], pys [32];
    logic [5:0] npts = 0;
    logic signed [6:0] winding_out;
    int n_cmp = 0, n_bad = 0;
`ifdef IN_POLYGON_WINDING_EN
    localparam int WEN = 1;
`else
    localparam int WEN = 0;
`endif

    in_polygon_stream dut (
        .clk_in(clk), .rst_in(rst), .valid_in(valid_in), .ready_out(ready_out),
        .x_in(x), .y_in(y), .poly_xs_in(pxs), .poly_ys_in(pys), .num_points_in(npts),
        .mode_in(mode), .busy_out(busy_out), .valid_out(valid_out), .ready_in(ready_in),
        .inside_out(inside_out), .winding_out(winding_out)
    );

    always #5 clk = ~clk;

    task automatic set_poly(input bit cw);
        for (int i = 0; i < 32; i++) begin
            case (i % 4)
                0: begin pxs[i] = 0; pys[i] = 0; end
                1: begin pxs[i] = cw ? 0 : 10; pys[i] = cw ? 10 : 0; end
                2: begin pxs[i] = 10; pys[i] = 10; end
                default: begin pxs[i] = cw ? 10 : 0; pys[i] = cw ? 0 : 10; end
            endcase
        end
    endtask

    task automatic query(input int n, input bit m, input int qx, input int qy, output int lat);
        @(negedge clk);
        npts = 6'(n); mode = m; x = qx; y = qy; valid_in = 1;
        @(posedge clk);
        #1 valid_in = 0;
        lat = 1;
        @(negedge clk);
        while (!valid_out && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        ready_in = 1;
        @(posedge clk);
        #1 ready_in = 0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({valid_out, inside_out, busy_out, ready_out} !== 4'b0001 || winding_out !== 7'sd0) begin
            n_bad++;
            $display("FAIL reset: v/in/busy/rdy=%b%b%b%b w=%0d, need 0001 w=0", valid_out, inside_out, busy_out, ready_out, winding_out);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_square();
        int qx [4] = '{5, 15, 5, 5};
        int qy [4] = '{5, 5, 0, 10};
        bit ei [4] = '{1, 0, 1, 0};
        int ew [4] = '{1, 0, 1, 0};
        int lat;
        set_poly(0);
        for (int k = 0; k < 4; k++) begin
            query(4, 0, qx[k], qy[k], lat);
            n_cmp += 3;
            if (lat != 4) begin n_bad++; $display("FAIL sq%0d latency: got %0d need 4", k, lat); end
            if (inside_out !== ei[k]) begin n_bad++; $display("FAIL sq%0d inside: got %b need %b", k, inside_out, ei[k]); end
            if (winding_out !== 7'(ew[k] * WEN)) begin n_bad++; $display("FAIL sq%0d winding: got %0d need %0d", k, winding_out, ew[k] * WEN); end
            consume();
        end
    endtask

    task automatic test_cw();
        int lat;
        set_poly(1);
        query(4, 1, 5, 5, lat);
        n_cmp += 2;
        if (inside_out !== 1'b1) begin n_bad++; $display("FAIL cw inside: got %b need 1", inside_out); end
        if (winding_out !== 7'(-WEN)) begin n_bad++; $display("FAIL cw winding: got %0d need %0d", winding_out, -WEN); end
        consume();
    endtask

    task automatic test_overlap();
        int lat;
        set_poly(0);
        query(8, 0, 5, 5, lat);
        n_cmp += 2;
        if (inside_out !== 1'b0) begin n_bad++; $display("FAIL ovl m0 inside: got %b need 0", inside_out); end
        if (lat != 5) begin n_bad++; $display("FAIL ovl latency: got %0d need 5", lat); end
        consume();
        query(8, 1, 5, 5, lat);
        n_cmp += 2;
        if (inside_out !== 1'(WEN)) begin n_bad++; $display("FAIL ovl m1 inside: got %b need %0d", inside_out, WEN); end
        if (winding_out !== 7'(2 * WEN)) begin n_bad++; $display("FAIL ovl m1 winding: got %0d need %0d", winding_out, 2 * WEN); end
        consume();
    endtask

    task automatic test_short();
        int lat;
        set_poly(0);
        for (int n = 0; n < 3; n += 2) begin
            query(n, 1, 5, 5, lat);
            n_cmp += 2;
            if (lat != 1) begin n_bad++; $display("FAIL short n=%0d latency: got %0d need 1", n, lat); end
            if (inside_out !== 1'b0 || winding_out !== 7'sd0) begin n_bad++; $display("FAIL short n=%0d result: in=%b w=%0d need 0/0", n, inside_out, winding_out); end
            consume();
        end
    endtask

    task automatic test_full();
        int lat;
        set_poly(0);
        for (int n = 32; n <= 40; n += 8) begin
            query(n, 1, 5, 5, lat);
            n_cmp += 3;
            if (lat != 11) begin n_bad++; $display("FAIL full n=%0d latency: got %0d need 11", n, lat); end
            if (inside_out !== 1'(WEN)) begin n_bad++; $display("FAIL full n=%0d inside: got %b need %0d", n, inside_out, WEN); end
            if (winding_out !== 7'(8 * WEN)) begin n_bad++; $display("FAIL full n=%0d winding: got %0d need %0d", n, winding_out, 8 * WEN); end
            consume();
        end
    endtask

    task automatic test_hold();
        int lat;
        set_poly(0);
        query(4, 0, 5, 5, lat);
        x = 15;
        valid_in = 1;
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if ({valid_out, inside_out, ready_out, busy_out} !== 4'b1101) begin
                n_bad++;
                $display("FAIL hold c%0d: v/in/rdy/busy=%b%b%b%b need 1101", c, valid_out, inside_out, ready_out, busy_out);
            end
            @(negedge clk);
        end
        valid_in = 0;
        consume();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
                n_bad++;
                $display("FAIL after hold c%0d: rdy=%b v=%b need 1/0", c, ready_out, valid_out);
            end
        end
    endtask

    task automatic test_midreset();
        int lat;
        set_poly(0);
        @(negedge clk);
        npts = 32; x = 5; y = 5; valid_in = 1;
        @(posedge clk);
        #1 valid_in = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        #1;
        n_cmp++;
        if ({valid_out, busy_out, ready_out} !== 3'b001) begin
            n_bad++;
            $display("FAIL midreset: v/busy/rdy=%b%b%b need 001", valid_out, busy_out, ready_out);
        end
        @(negedge clk);
        rst = 0;
        query(4, 0, 5, 5, lat);
        n_cmp += 2;
        if (lat != 4) begin n_bad++; $display("FAIL post-reset latency: got %0d need 4", lat); end
        if (inside_out !== 1'b1) begin n_bad++; $display("FAIL post-reset inside: got %b need 1", inside_out); end
        consume();
    endtask

    initial begin
        set_poly(0);
        test_reset();
        test_square();
        test_cw();
        test_overlap();
        test_short();
        test_full();
        test_hold();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
